fifo_stream_unpacker: RTL and testbench

Read-side drain stage placed directly downstream of the team's synchronous FIFO. It issues FIFO reads, absorbs the FIFO's one-cycle registered read latency into a 2-word holding buffer, and serializes each DATA_WIDTH word into DATA_WIDTH/OUT_WIDTH narrower beats on a valid/ready stream toward the RTL model's consumer port. The FIFO's `full`/write side is not used here.

---
 rtl/fifo_stream_unpacker.sv | 128 ++++++++++++
 tb/tb_fifo_stream_unpacker.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_unpacker.sv
// Drains a registered-read FIFO into a 2-word buffer and serializes each word into OUT_WIDTH beats, least-significant slice first.
// Optional FIFO_UNPACK_STATS_EN adds the words_done counter port.
module fifo_stream_unpacker #(
  parameter int DATA_WIDTH = 64,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
`ifdef FIFO_UNPACK_STATS_EN
  ,
  output logic [15:0]           words_done
`endif
);

  localparam int RATIO  = DATA_WIDTH / OUT_WIDTH;
  localparam int BIDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(RATIO - 1);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] buf_mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic                  inflight;
  logic [BIDX_W-1:0]     bidx;
  logic                  capture;
  logic                  beat_fire;
  logic                  pop;
  logic [2:0]            demand;
  logic [OUT_WIDTH-1:0]  head_slice;

  assign capture   = inflight;
  assign beat_fire = out_valid && out_ready;
  assign pop       = beat_fire && (bidx == LAST_IDX);

  // Words held plus the one in flight, minus the one leaving this cycle, must stay below 2.
  assign demand     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = rst_n && !fifo_empty && (demand < 3'd2);

  always_comb begin
    occ_next = occ;
    case ({capture, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (capture) state_next = STREAM;
      end
      STREAM: begin
        if (pop && (occ == 2'd1) && !capture) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= 1'b0;
      tail     <= 1'b0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      bidx     <= '0;
    end else begin
      inflight <= fifo_rd_en;
      occ      <= occ_next;
      if (capture) tail <= ~tail;
      if (pop)     head <= ~head;
      if (beat_fire) begin
        bidx <= (bidx == LAST_IDX) ? '0 : bidx + BIDX_W'(1);
      end
    end
  end

  // Storage needs no reset: nothing reads a slot before a capture fills it.
  always_ff @(posedge clk) begin
    if (capture) buf_mem[tail] <= fifo_data;
  end

  always_comb begin
    head_slice = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (bidx == BIDX_W'(i)) head_slice = buf_mem[head][i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  assign out_valid = (state == STREAM);
  assign out_data  = out_valid ? head_slice : '0;
  assign out_last  = out_valid && (bidx == LAST_IDX);

`ifdef FIFO_UNPACK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_done <= 16'd0;
    end else if (pop) begin
      words_done <= words_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_unpacker.sv
// Self-checking bench for fifo_stream_unpacker: a 4:1 instance and a 1:1 instance, each fed by a FIFO model.
// Expected beats are queued when words are pushed and compared as the DUT emits them.
module tb_fifo_stream_unpacker;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] fifo_data_a = '0;
  logic        fifo_empty_a;
  logic        rd_en_a;
  logic [15:0] out_data_a;
  logic        out_valid_a;
  logic        out_ready_a = 1'b1;
  logic        out_last_a;

  logic [63:0] fifo_data_b = '0;
  logic        fifo_empty_b;
  logic        rd_en_b;
  logic [63:0] out_data_b;
  logic        out_valid_b;
  logic        out_ready_b = 1'b1;
  logic        out_last_b;

`ifdef FIFO_UNPACK_STATS_EN
  logic [15:0] words_done_a;
  logic [15:0] words_done_b;
`endif

  fifo_stream_unpacker #(.DATA_WIDTH(64), .OUT_WIDTH(16)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data_a),
    .fifo_empty (fifo_empty_a),
    .fifo_rd_en (rd_en_a),
    .out_data   (out_data_a),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready_a),
    .out_last   (out_last_a)
`ifdef FIFO_UNPACK_STATS_EN
    ,
    .words_done (words_done_a)
`endif
  );

  fifo_stream_unpacker #(.DATA_WIDTH(64), .OUT_WIDTH(64)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_data  (fifo_data_b),
    .fifo_empty (fifo_empty_b),
    .fifo_rd_en (rd_en_b),
    .out_data   (out_data_b),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready_b),
    .out_last   (out_last_b)
`ifdef FIFO_UNPACK_STATS_EN
    ,
    .words_done (words_done_b)
`endif
  );

  int total_checks = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  // FIFO models: the initial block writes words, the clocked block reads them with one-cycle latency.
  logic [63:0] mem_a [64];
  logic [63:0] mem_b [64];
  int pushed_a = 0;
  int popped_a = 0;
  int pushed_b = 0;
  int popped_b = 0;

  assign fifo_empty_a = (pushed_a == popped_a);
  assign fifo_empty_b = (pushed_b == popped_b);

  always @(posedge clk) begin
    if (rd_en_a) begin
      fifo_data_a <= mem_a[popped_a];
      popped_a    <= popped_a + 1;
    end
    if (rd_en_b) begin
      fifo_data_b <= mem_b[popped_b];
      popped_b    <= popped_b + 1;
    end
  end

  logic [16:0] exp_a [$];
  logic [64:0] exp_b [$];
  logic [16:0] e_a;
  logic [64:0] e_b;
  int words_exp = 0;
  logic bound_ok_a;
  logic bound_ok_b;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    assert (obs === exp) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus_a(input logic [63:0] w);
    mem_a[pushed_a] = w;
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back({(i == 3) ? 1'b1 : 1'b0, w[i*16 +: 16]});
    end
    pushed_a = pushed_a + 1;
  endtask

  task automatic apply_stimulus_b(input logic [63:0] w);
    mem_b[pushed_b] = w;
    exp_b.push_back({1'b1, w});
    pushed_b = pushed_b + 1;
  endtask

  task automatic wait_drain_a(output int n);
    n = 0;
    while (exp_a.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check_output("drain_a", 64'(exp_a.size()), 64'd0);
  endtask

  task automatic wait_drain_b(output int n);
    n = 0;
    while (exp_b.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check_output("drain_b", 64'(exp_b.size()), 64'd0);
  endtask

  // Scoreboard side: compare each accepted beat and enforce the read-ahead bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a.delete();
      exp_b.delete();
      words_exp = 0;
    end else begin
      bound_ok_a = (int'(dut_a.occ) + int'(dut_a.inflight)) <= 2;
      bound_ok_b = (int'(dut_b.occ) + int'(dut_b.inflight)) <= 2;
      check_output("occ_bound_a", 64'(bound_ok_a), 64'd1);
      check_output("occ_bound_b", 64'(bound_ok_b), 64'd1);
      if (out_valid_a && out_ready_a) begin
        if (exp_a.size() == 0) begin
          check_output("unexpected_beat_a", 64'(out_valid_a), 64'd0);
        end else begin
          e_a = exp_a.pop_front();
          check_output("beat_data_a", 64'(out_data_a), 64'(e_a[15:0]));
          check_output("beat_last_a", 64'(out_last_a), 64'(e_a[16]));
          if (e_a[16]) words_exp++;
        end
      end
      if (out_valid_b && out_ready_b) begin
        if (exp_b.size() == 0) begin
          check_output("unexpected_beat_b", 64'(out_valid_b), 64'd0);
        end else begin
          e_b = exp_b.pop_front();
          check_output("beat_data_b", out_data_b, e_b[63:0]);
          check_output("beat_last_b", 64'(out_last_b), 64'(e_b[64]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;

    // Reset with the FIFO empty.
    #1 rst_n = 1'b0;
    #2;
    check_output("reset_valid", 64'(out_valid_a), 64'd0);
    check_output("reset_last", 64'(out_last_a), 64'd0);
    check_output("reset_data", 64'(out_data_a), 64'd0);
    check_output("reset_rd_en", 64'(rd_en_a), 64'd0);
    check_output("reset_valid_b", 64'(out_valid_b), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check_output("idle_rd_en", 64'(rd_en_a), 64'd0);
    check_output("idle_valid", 64'(out_valid_a), 64'd0);

    // Single word, full-rate consumer.
    apply_stimulus_a(64'h4444_3333_2222_1111);
    #1;
    check_output("rd_en_issue", 64'(rd_en_a), 64'd1);
    step();
    check_output("rd_en_single", 64'(rd_en_a), 64'd0);
    check_output("latency_not_yet", 64'(out_valid_a), 64'd0);
    step();
    check_output("first_beat_valid", 64'(out_valid_a), 64'd1);
    check_output("first_beat_data", 64'(out_data_a), 64'h1111);
    wait_drain_a(n);
    check_output("single_word_cycles", 64'(n), 64'd4);
    check_output("single_word_idle", 64'(out_valid_a), 64'd0);
`ifdef FIFO_UNPACK_STATS_EN
    check_output("words_done_1", 64'(words_done_a), 64'(words_exp));
`endif

    // Backpressure at beat 0x2222 while two more words arrive.
    apply_stimulus_a(64'h4444_3333_2222_1111);
    step();
    step();
    step();
    out_ready_a = 1'b0;
    apply_stimulus_a(64'h8888_7777_6666_5555);
    apply_stimulus_a(64'hCCCC_BBBB_AAAA_9999);
    for (int k = 0; k < 3; k++) begin
      check_output("stall_data", 64'(out_data_a), 64'h2222);
      check_output("stall_valid", 64'(out_valid_a), 64'd1);
      step();
    end
    check_output("stall_data_4th", 64'(out_data_a), 64'h2222);
    check_output("stall_last", 64'(out_last_a), 64'd0);
    check_output("stall_occ_full", 64'(dut_a.occ), 64'd2);
    out_ready_a = 1'b1;
    wait_drain_a(n);
`ifdef FIFO_UNPACK_STATS_EN
    check_output("words_done_4", 64'(words_done_a), 64'(words_exp));
`endif

    // Three words back-to-back.
    step();
    apply_stimulus_a(64'h0123_4567_89AB_CDEF);
    apply_stimulus_a(64'hFEDC_BA98_7654_3210);
    apply_stimulus_a(64'h5A5A_A5A5_0F0F_F0F0);
    step();
    step();
    check_output("b2b_first_data", 64'(out_data_a), 64'hCDEF);
    wait_drain_a(n);
    check_output("b2b_cycles", 64'(n), 64'd12);
    check_output("b2b_idle", 64'(out_valid_a), 64'd0);
`ifdef FIFO_UNPACK_STATS_EN
    check_output("words_done_7", 64'(words_done_a), 64'(words_exp));
`endif

    // Reset mid-word after beat 0x2222 has been accepted.
    apply_stimulus_a(64'h4444_3333_2222_1111);
    step();
    step();
    step();
    step();
    check_output("pre_reset_data", 64'(out_data_a), 64'h3333);
    rst_n = 1'b0;
    #1;
    check_output("midreset_valid", 64'(out_valid_a), 64'd0);
    check_output("midreset_last", 64'(out_last_a), 64'd0);
    check_output("midreset_data", 64'(out_data_a), 64'd0);
`ifdef FIFO_UNPACK_STATS_EN
    check_output("midreset_words_done", 64'(words_done_a), 64'd0);
`endif
    step();
    apply_stimulus_a(64'hDDDD_CCCC_BBBB_AAAA);
    #1;
    check_output("reset_blocks_rd_en", 64'(rd_en_a), 64'd0);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_rd_en", 64'(rd_en_a), 64'd1);
    step();
    step();
    check_output("post_reset_first", 64'(out_data_a), 64'hAAAA);
    wait_drain_a(n);

    // RATIO=1 instance with a 4-word stream.
    apply_stimulus_b(64'h1111_1111_1111_1111);
    apply_stimulus_b(64'h2222_2222_2222_2222);
    apply_stimulus_b(64'h3333_3333_3333_3333);
    apply_stimulus_b(64'h4444_4444_4444_4444);
    #1;
    check_output("r1_rd_en", 64'(rd_en_b), 64'd1);
    step();
    step();
    check_output("r1_first_last", 64'(out_last_b), 64'd1);
    wait_drain_b(n);
    check_output("r1_cycles", 64'(n), 64'd4);
    check_output("r1_idle", 64'(out_valid_b), 64'd0);

    step();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
